// File: rtl/mac_result_buffer.sv
// Result FIFO behind the MAC: tags each result with its mode, optionally saturates it, and drops on overflow.
// Optional feature macro: MAC_RESULT_SAT_EN (saturate to signed OUT_W instead of wrapping).
module mac_result_buffer #(
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_output,
  input  logic signed [IN_W-1:0]         final_output,
  input  logic                           mode,
  input  logic                           clr_err,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_mode,
  output logic                           out_sat,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow_err,
  output logic [7:0]                     drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = OUT_W + 2;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic             r_overflow_err;
  logic [7:0]       r_drop_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_drop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [OUT_W-1:0] w_data;
  logic             w_sat;
  logic [ENT_W-1:0] w_head;

  // Entry payload is formed at write time so the head never changes while stalled.
`ifdef MAC_RESULT_SAT_EN
  localparam logic signed [IN_W-1:0] L_MAX = IN_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [IN_W-1:0] L_MIN = ~L_MAX;

  always_comb begin
    w_data = final_output[OUT_W-1:0];
    w_sat  = 1'b0;
    if (final_output > L_MAX) begin
      w_data = L_MAX[OUT_W-1:0];
      w_sat  = 1'b1;
    end else if (final_output < L_MIN) begin
      w_data = L_MIN[OUT_W-1:0];
      w_sat  = 1'b1;
    end
  end
`else
  logic w_unused_bits;
  assign w_unused_bits = ^final_output;
  assign w_data        = final_output[OUT_W-1:0];
  assign w_sat         = 1'b0;
`endif

  assign w_push = valid_output;
  assign w_pop  = r_out_valid & out_ready;
  assign w_full = (r_count == CNT_W'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Control state: pointers, occupancy and error reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_out_valid    <= 1'b0;
      r_overflow_err <= 1'b0;
      r_drop_cnt     <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      if (clr_err) begin
        r_overflow_err <= 1'b0;
        r_drop_cnt     <= '0;
      end else if (w_drop) begin
        r_overflow_err <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Storage is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && w_wr) r_mem[r_wr_ptr] <= {mode, w_sat, w_data};
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign out_data     = w_head[OUT_W-1:0];
  assign out_sat      = w_head[OUT_W];
  assign out_mode     = w_head[ENT_W-1];
  assign out_valid    = r_out_valid;
  assign count        = r_count;
  assign overflow_err = r_overflow_err;
  assign drop_cnt     = r_drop_cnt;

endmodule
